// File: rtl/fb_pkg.sv
// Frame-buffer write path shared definitions.
// Holds the screen geometry, the frame-buffer word/address widths, the
// queued pixel record and the output FSM state encoding used by
// pixel_write_queue and pixel_fifo.
package fb_pkg;

  localparam int H_RES     = 320;
  localparam int V_RES     = 240;
  localparam int FB_ADDR_W = 17;
  localparam int COLOUR_W  = 15;

  typedef struct packed {
    logic [8:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic {
    WQ_IDLE  = 1'b0,
    WQ_WRITE = 1'b1
  } wq_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock first-word-fall-through FIFO of pixel records.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push, din    : enqueue din at the tail (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO, overrides push/pop
//   dout         : current head entry, valid while !empty
//   full, empty  : occupancy flags
//   count        : occupancy, 0..DEPTH
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  pixel_t                 din,
  output pixel_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_queue.sv
// Pixel write queue: buffers (x, y, colour) pixel writes from the drawing
// datapath and commits them to the 320x240 RGB555 frame buffer as linear
// word writes, absorbing frame-buffer stalls.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   in_valid/in_ready           : pixel handshake, accepted when both high
//   in_x, in_y, in_colour       : pixel column, row and RGB555 colour
//   flush                       : discard queued pixels and any stalled write
//   fb_stall                    : frame-buffer port busy
//   fb_we, fb_addr, fb_data     : frame-buffer write strobe, address, colour
//   count                       : FIFO occupancy
//   idle                        : FIFO empty and no write pending
//   clip_cnt                    : saturating count of clipped pixels
//                                 (present only with PIXEL_CLIP_EN)
// Build option: define PIXEL_CLIP_EN to drop off-screen pixels instead of
// writing them to raw (possibly out-of-range) addresses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WQ_IDLE  | no write presented, fb_we low
// WQ_WRITE | fb_addr/fb_data presented with fb_we high until !fb_stall
module pixel_write_queue #(
  parameter int DEPTH = 16,
  parameter int H_RES = fb_pkg::H_RES,
  parameter int V_RES = fb_pkg::V_RES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8:0]             in_x,
  input  logic [7:0]             in_y,
  input  logic [14:0]            in_colour,
  input  logic                   flush,
  input  logic                   fb_stall,
  output logic                   fb_we,
  output logic [16:0]            fb_addr,
  output logic [14:0]            fb_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   idle
`ifdef PIXEL_CLIP_EN
  ,
  output logic [15:0]            clip_cnt
`endif
);

  import fb_pkg::*;

  wq_state_t              state;
  wq_state_t              state_nxt;
  pixel_t                 fifo_din;
  pixel_t                 fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [FB_ADDR_W-1:0]   x_ext;
  logic [FB_ADDR_W-1:0]   y_ext;
  logic [FB_ADDR_W-1:0]   pop_addr;

  // fifo_full is exactly count == DEPTH.
  assign in_ready = !reset && !flush && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign fifo_din = '{x: in_x, y: in_y, colour: in_colour};

`ifdef PIXEL_CLIP_EN
  localparam logic [8:0] X_LIM = 9'(H_RES);
  localparam logic [7:0] Y_LIM = 8'(V_RES);

  logic in_range;
  assign in_range = (in_x < X_LIM) && (in_y < Y_LIM);
  assign push     = accept && in_range;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      clip_cnt <= '0;
    end else if (accept && !in_range && (clip_cnt != 16'hFFFF)) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end
`else
  assign push = accept;
`endif

  pixel_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // y*320 as (y<<8)+(y<<6), widened to the full address width first.
  assign x_ext    = FB_ADDR_W'(fifo_dout.x);
  assign y_ext    = FB_ADDR_W'(fifo_dout.y);
  assign pop_addr = (y_ext << 8) + (y_ext << 6) + x_ext;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      WQ_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WQ_WRITE;
        end
      end
      WQ_WRITE: begin
        if (!fb_stall) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = WQ_IDLE;
        end
      end
      default: state_nxt = WQ_IDLE;
    endcase
    // A stalled write is abandoned rather than completed.
    if (flush) begin
      pop       = 1'b0;
      state_nxt = WQ_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WQ_IDLE;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        fb_addr <= pop_addr;
        fb_data <= fifo_dout.colour;
      end
    end
  end

  assign fb_we = (state == WQ_WRITE);
  assign idle  = (count == '0) && (state == WQ_IDLE);

endmodule
